cluster_cmd_issuer: RTL
=======================

CLUSTER_CMD_ISSUER -- requirements
Module: cluster_cmd_issuer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8, number of issuing cores.
REQ-002 SHALL have parameter NUM_CMD_IDS, default 8, outstanding-command slots per cluster (power of two, 2..32).
REQ-003 SHALL have parameter CLUSTER_ID_W, default 4, width of cluster identifier.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 cluster_id_i  in  CLUSTER_ID_W  static id of this cluster.
REQ-007 core_req_valid_i / core_req_ready_o  in/out  NUM_CORES  per-core issue handshake.
REQ-008 core_req_i  in  NUM_CORES x pspin_cmd_t  command from each core (cmd_id field ignored).
REQ-009 core_req_id_o  out  $clog2(NUM_CMD_IDS)  local id assigned, valid in the cycle of core handshake.
REQ-010 cmd_valid_o / cmd_ready_i / cmd_o  out/in/out  1/1/pspin_cmd_t  command stream to cmd_unit.
REQ-011 cmd_resp_valid_i / cmd_resp_i  in  1/pspin_cmd_resp_t  broadcast responses from cmd_unit (no backpressure).
REQ-012 cmd_done_o  out  NUM_CMD_IDS  per-id completion bitmap.
REQ-013 cmd_clear_valid_i / cmd_clear_id_i  in  1/$clog2(NUM_CMD_IDS)  core releases a completed id.
REQ-014 err_spurious_o  out  1  sticky: response for an id not in flight.

Function
REQ-015 Id states: FREE -> INFLIGHT (on issue) -> DONE (on matching response) -> FREE (on clear).
REQ-016 core_req_ready_o[i] high only if core i wins round-robin among valid cores, a FREE id exists, and output register empty or draining this cycle.
REQ-017 Allocated id = lowest-index FREE id; cmd_o.cmd_id = {cluster_id_i, local id}.
REQ-018 Round-robin pointer advances past the winner only on handshake; lock-in held while chosen core stays valid.
REQ-019 Output register: one stage; cmd_valid_o asserted cycle after core handshake; cmd_o stable while cmd_valid_o && !cmd_ready_i; full throughput 1 cmd/cycle.
REQ-020 Response matches when cmd_resp_valid_i and resp cluster field == cluster_id_i; others ignored silently.
REQ-021 Matching response to INFLIGHT id: cmd_done_o bit set next cycle.
REQ-022 Matching response to FREE or DONE id: no state change, err_spurious_o set next cycle, held until reset.
REQ-023 Clear on DONE id: id FREE next cycle, done bit cleared; clear on non-DONE id ignored.
REQ-024 Id freed in cycle N allocatable from cycle N+1 only.
REQ-025 Response and clear on same id same cycle: response processed, clear ignored (id not yet DONE).
REQ-026 All NUM_CMD_IDS INFLIGHT/DONE: all core_req_ready_o low; no command dropped.

Reset
REQ-027 Reset: all ids FREE, cmd_valid_o=0, core_req_ready_o=0, cmd_done_o=0, err_spurious_o=0, rr pointer=0, counters=0.
REQ-028 Reset mid-operation discards the output register and all in-flight state; later responses for old ids flag err_spurious_o.

Configuration
REQ-029 Macro CMD_ISSUER_STATS_EN defined: 32-bit outputs stat_issued_o and stat_completed_o count handshakes on cmd_o and matched INFLIGHT responses, wrapping modulo 2^32.
REQ-030 Macro undefined: stat_issued_o/stat_completed_o present, tied to 0, no counter flops.

Structure
REQ-031 pspin_cfg_pkg holds pspin_cmd_t, pspin_cmd_resp_t, cmd id field widths, CLUSTER_ID_W default.
REQ-032 Sub-module cmd_id_allocator: free bitmap, lowest-index find, alloc/free ports; reused by top.

Verification
REQ-033 Reset, core 3 issues intf_id=1 -> id 0, cmd_o.cmd_id={cluster,0} next cycle, held 4 cycles under cmd_ready_i=0.
REQ-034 Cores 0,1,2 valid continuously, cmd_ready_i=1 -> grants 0,1,2,0... ids 0..7 then all ready low at 9th request.
REQ-035 Response id 5 for INFLIGHT id 5 -> cmd_done_o=0x20 next cycle; clear id 5 -> 0x00, next request gets id 5.
REQ-036 Response with other cluster_id -> no change; response for FREE id 2 -> err_spurious_o=1 sticky.
REQ-037 Response and clear id 4 same cycle with id 4 INFLIGHT -> done bit set, id 4 stays allocated.
REQ-038 With CMD_ISSUER_STATS_EN: 10 issues, 7 responses -> stat_issued_o=10, stat_completed_o=7; without: both 0.

Source files
------------

// File: rtl/pspin_cfg_pkg.sv
// Shared command/response types and id field widths for the cluster command path.
package pspin_cfg_pkg;

    localparam int DEFAULT_CLUSTER_ID_W = 4;
    localparam int CMD_LOCAL_ID_W       = 5;
    localparam int CMD_ID_W             = DEFAULT_CLUSTER_ID_W + CMD_LOCAL_ID_W;
    localparam int INTF_ID_W            = 4;

    typedef logic [CMD_ID_W-1:0] cmd_id_t;

    typedef enum logic [1:0] {
        CMD_HOST_DMA = 2'd0,
        CMD_NIC_SEND = 2'd1,
        CMD_CUSTOM   = 2'd2,
        CMD_NOP      = 2'd3
    } cmd_type_e;

    typedef struct packed {
        logic [INTF_ID_W-1:0] intf_id;
        cmd_type_e            cmd_type;
        cmd_id_t              cmd_id;
        logic [31:0]          descr;
    } pspin_cmd_t;

    typedef struct packed {
        cmd_id_t cmd_id;
    } pspin_cmd_resp_t;

    function automatic cmd_id_t make_cmd_id(input logic [DEFAULT_CLUSTER_ID_W-1:0] cluster,
                                            input logic [CMD_LOCAL_ID_W-1:0]       local_id);
        return {cluster, local_id};
    endfunction

endpackage

// File: rtl/cmd_id_allocator.sv
// Free-id bitmap with lowest-index allocation; a freed id is allocatable the cycle after.
module cmd_id_allocator #(
    parameter int  NUM_IDS = 8,
    localparam int ID_W    = $clog2(NUM_IDS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               alloc_i,
    input  logic               free_valid_i,
    input  logic [ID_W-1:0]    free_id_i,
    output logic               avail_o,
    output logic [ID_W-1:0]    alloc_id_o,
    output logic [NUM_IDS-1:0] free_map_o
);

    logic [NUM_IDS-1:0] free_r;
    logic [NUM_IDS-1:0] alloc_mask_s;
    logic [NUM_IDS-1:0] free_mask_s;
    logic [ID_W-1:0]    lowest_s;

    // Lowest-index free id: scan downwards so the smallest set bit wins.
    always_comb begin
        lowest_s = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            lowest_s = free_r[i] ? ID_W'(i) : lowest_s;
        end
    end

    // One-hot update masks for this cycle's allocation and release.
    always_comb begin
        alloc_mask_s = '0;
        free_mask_s  = '0;
        if (alloc_i && avail_o) begin
            alloc_mask_s[lowest_s] = 1'b1;
        end else begin
            alloc_mask_s = '0;
        end
        if (free_valid_i) begin
            free_mask_s[free_id_i] = 1'b1;
        end else begin
            free_mask_s = '0;
        end
    end

    // Free bitmap register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            free_r <= '1;
        end else begin
            free_r <= (free_r & ~alloc_mask_s) | free_mask_s;
        end
    end

    assign avail_o    = |free_r;
    assign alloc_id_o = lowest_s;
    assign free_map_o = free_r;

endmodule

// File: rtl/cluster_cmd_issuer.sv
// Arbitrates core commands onto one cmd stream, tracks per-id completion.
// Optional counters enabled by defining CMD_ISSUER_STATS_EN.
module cluster_cmd_issuer
    import pspin_cfg_pkg::*;
#(
    parameter int  NUM_CORES    = 8,
    parameter int  NUM_CMD_IDS  = 8,
    parameter int  CLUSTER_ID_W = DEFAULT_CLUSTER_ID_W,
    localparam int ID_W         = $clog2(NUM_CMD_IDS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [CLUSTER_ID_W-1:0]       cluster_id_i,
    input  logic [NUM_CORES-1:0]          core_req_valid_i,
    output logic [NUM_CORES-1:0]          core_req_ready_o,
    input  pspin_cmd_t [NUM_CORES-1:0]    core_req_i,
    output logic [ID_W-1:0]               core_req_id_o,
    output logic                          cmd_valid_o,
    input  logic                          cmd_ready_i,
    output pspin_cmd_t                    cmd_o,
    input  logic                          cmd_resp_valid_i,
    input  pspin_cmd_resp_t               cmd_resp_i,
    output logic [NUM_CMD_IDS-1:0]        cmd_done_o,
    input  logic                          cmd_clear_valid_i,
    input  logic [ID_W-1:0]               cmd_clear_id_i,
    output logic                          err_spurious_o,
    output logic [31:0]                   stat_issued_o,
    output logic [31:0]                   stat_completed_o
);

    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [CORE_W-1:0]               rr_ptr_r, lock_core_r, rr_pick_s, win_core_s, rr_next_s;
    logic                            lock_r, rr_found_s, win_valid_s;
    logic                            id_avail_s, can_load_s, core_hs_s;
    logic [ID_W-1:0]                 alloc_id_s;
    logic [NUM_CMD_IDS-1:0]          free_map_s, done_r, done_set_s, done_clr_s;
    logic                            out_valid_r, err_r;
    pspin_cmd_t                      out_cmd_r, load_cmd_s;
    logic [DEFAULT_CLUSTER_ID_W-1:0] cluster_fld_s, resp_cluster_s;
    logic [CMD_LOCAL_ID_W-1:0]       resp_local_s;
    logic [ID_W-1:0]                 resp_id_s;
    logic                            resp_match_s, resp_inflight_s, resp_spurious_s, clear_hit_s;

    assign cluster_fld_s  = DEFAULT_CLUSTER_ID_W'(cluster_id_i);
    assign resp_cluster_s = cmd_resp_i.cmd_id[CMD_ID_W-1:CMD_LOCAL_ID_W];
    assign resp_local_s   = cmd_resp_i.cmd_id[CMD_LOCAL_ID_W-1:0];
    assign resp_id_s      = resp_local_s[ID_W-1:0];

    // Round-robin search starting at the pointer.
    always_comb begin
        int   idx_v;
        logic hit_v;
        idx_v      = 0;
        hit_v      = 1'b0;
        rr_found_s = 1'b0;
        rr_pick_s  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx_v      = (int'(rr_ptr_r) + k) % NUM_CORES;
            hit_v      = !rr_found_s && core_req_valid_i[idx_v];
            rr_pick_s  = hit_v ? CORE_W'(idx_v) : rr_pick_s;
            rr_found_s = rr_found_s | hit_v;
        end
    end

    // A chosen core keeps the grant until it handshakes or drops valid.
    always_comb begin
        if (lock_r && core_req_valid_i[lock_core_r]) begin
            win_valid_s = 1'b1;
            win_core_s  = lock_core_r;
        end else begin
            win_valid_s = rr_found_s;
            win_core_s  = rr_pick_s;
        end
    end

    assign can_load_s = !out_valid_r || cmd_ready_i;
    assign rr_next_s  = (int'(win_core_s) == NUM_CORES - 1) ? '0 : win_core_s + CORE_W'(1);

    // Ready only to the winner, and only when an id and the output stage are available.
    always_comb begin
        core_req_ready_o = '0;
        if (rst_ni && win_valid_s && id_avail_s && can_load_s) begin
            core_req_ready_o[win_core_s] = 1'b1;
        end else begin
            core_req_ready_o = '0;
        end
    end

    assign core_hs_s     = |(core_req_valid_i & core_req_ready_o);
    assign core_req_id_o = alloc_id_s;

    // Command captured into the output stage with the cluster-qualified id.
    always_comb begin
        load_cmd_s        = core_req_i[win_core_s];
        load_cmd_s.cmd_id = make_cmd_id(cluster_fld_s, CMD_LOCAL_ID_W'(alloc_id_s));
    end

    cmd_id_allocator #(
        .NUM_IDS (NUM_CMD_IDS)
    ) u_alloc (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_i      (core_hs_s),
        .free_valid_i (clear_hit_s),
        .free_id_i    (cmd_clear_id_i),
        .avail_o      (id_avail_s),
        .alloc_id_o   (alloc_id_s),
        .free_map_o   (free_map_s)
    );

    // Arbitration pointer and lock-in state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_r    <= '0;
            lock_r      <= 1'b0;
            lock_core_r <= '0;
        end else if (core_hs_s) begin
            rr_ptr_r <= rr_next_s;
            lock_r   <= 1'b0;
        end else if (win_valid_s) begin
            lock_r      <= 1'b1;
            lock_core_r <= win_core_s;
        end else begin
            lock_r <= 1'b0;
        end
    end

    // Single output stage; holds its command while the sink stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            out_cmd_r   <= '0;
        end else if (core_hs_s) begin
            out_valid_r <= 1'b1;
            out_cmd_r   <= load_cmd_s;
        end else if (cmd_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Out-of-range local ids cannot belong to this cluster's id space.
    assign resp_match_s    = cmd_resp_valid_i && (resp_cluster_s == cluster_fld_s)
                             && ((resp_local_s >> ID_W) == '0);
    assign resp_inflight_s = resp_match_s && !free_map_s[resp_id_s] && !done_r[resp_id_s];
    assign resp_spurious_s = resp_match_s && !resp_inflight_s;
    assign clear_hit_s     = cmd_clear_valid_i && done_r[cmd_clear_id_i];

    // Done set/clear masks.
    always_comb begin
        done_set_s = '0;
        done_clr_s = '0;
        if (resp_inflight_s) begin
            done_set_s[resp_id_s] = 1'b1;
        end else begin
            done_set_s = '0;
        end
        if (clear_hit_s) begin
            done_clr_s[cmd_clear_id_i] = 1'b1;
        end else begin
            done_clr_s = '0;
        end
    end

    // Completion bitmap and sticky spurious-response flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            done_r <= '0;
            err_r  <= 1'b0;
        end else begin
            done_r <= (done_r | done_set_s) & ~done_clr_s;
            err_r  <= err_r | resp_spurious_s;
        end
    end

    assign cmd_valid_o    = out_valid_r;
    assign cmd_o          = out_cmd_r;
    assign cmd_done_o     = done_r;
    assign err_spurious_o = err_r;

`ifdef CMD_ISSUER_STATS_EN
    logic [31:0] stat_issued_r, stat_completed_r;

    // Free-running, wrapping event counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_issued_r    <= 32'd0;
            stat_completed_r <= 32'd0;
        end else begin
            stat_issued_r    <= stat_issued_r + {31'd0, out_valid_r && cmd_ready_i};
            stat_completed_r <= stat_completed_r + {31'd0, resp_inflight_s};
        end
    end

    assign stat_issued_o    = stat_issued_r;
    assign stat_completed_o = stat_completed_r;
`else
    assign stat_issued_o    = 32'd0;
    assign stat_completed_o = 32'd0;
`endif

endmodule
